// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, idle bus
// values and the command-bus arbiter state type.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP         = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
  localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;

  // Bus values driven while nobody owns the bus
  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [11:0] IDLE_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    StInit,
    StArbit,
    StAref,
    StWrite,
    StRead
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter.sv
// Command-bus arbiter for the SDRAM controller.
// Grants the single command/bank/address bus to one of four sources: the init
// sequencer until init_done, then refresh first and round-robin write/read.
// The owner's command is registered onto sdram_*; an owner that never signals
// its end is force-released after TIMEOUT_CYCLES busy cycles.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   init_done               init sequence complete (falling edge returns to INIT)
//   init_cmd/ba/addr        init sequencer command
//   ar_req/ar_end/ar_en     refresh request, finished, grant pulse
//   wr_req/wr_end/wr_en     write request, burst finished, grant pulse
//   rd_req/rd_end/rd_en     read request, burst finished, grant pulse
//   *_cmd/*_ba/*_addr       per-source command, bank and address
//   sdram_cmd/ba/addr       registered device command bus
//   timeout_err             sticky: an owner was force-released
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        ar_req,
  input  logic        ar_end,
  input  logic [3:0]  ar_cmd,
  input  logic [1:0]  ar_ba,
  input  logic [11:0] ar_addr,
  output logic        ar_en,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        timeout_err
);

  // The counter is cleared on entry, so busy cycle k sees cnt_q == k; releasing
  // when cnt_q hits TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES busy cycles.
  localparam logic [9:0] CntLast = 10'(TIMEOUT_CYCLES - 1);

  arb_state_e  state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        err_d;
  logic        busy, owner_end, timeout_hit;
  logic        grant_ar, grant_wr, grant_rd;
  logic [3:0]  cmd_d;
  logic [1:0]  ba_d;
  logic [11:0] addr_d;

  always_comb begin
    busy      = state_q inside {StAref, StWrite, StRead};
    owner_end = 1'b0;
    case (state_q)
      StAref:  owner_end = ar_end;
      StWrite: owner_end = wr_end;
      StRead:  owner_end = rd_end;
      default: owner_end = 1'b0;
    endcase
    timeout_hit = busy && !owner_end && (cnt_q == CntLast);
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    if (!init_done) begin
      state_d = StInit;
    end else begin
      unique case (state_q)
        StInit:  state_d = StArbit;
        StArbit: begin
          if (ar_req) begin
            state_d = StAref;
          end else if (wr_req && (!rd_req || !last_wr_q)) begin
            state_d = StWrite;
          end else if (rd_req) begin
            state_d = StRead;
          end
        end
        StAref, StWrite, StRead: begin
          if (owner_end || timeout_hit) state_d = StArbit;
        end
        default: state_d = StInit;
      endcase
    end
  end

  // Grants, round-robin flag, timeout counter and error flag
  always_comb begin
    grant_ar  = (state_q == StArbit) && (state_d == StAref);
    grant_wr  = (state_q == StArbit) && (state_d == StWrite);
    grant_rd  = (state_q == StArbit) && (state_d == StRead);
    last_wr_d = last_wr_q;
    if (grant_wr) last_wr_d = 1'b1;
    if (grant_rd) last_wr_d = 1'b0;
    cnt_d = '0;
    if (busy && (state_d == state_q)) cnt_d = cnt_q + 10'd1;
    err_d = timeout_err | (timeout_hit && init_done);
  end

  // Output mux on the current owner; registered below
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = IDLE_BA;
    addr_d = IDLE_ADDR;
    case (state_q)
      StInit:  begin cmd_d = init_cmd; ba_d = init_ba; addr_d = init_addr; end
      StAref:  begin cmd_d = ar_cmd;   ba_d = ar_ba;   addr_d = ar_addr;   end
      StWrite: begin cmd_d = wr_cmd;   ba_d = wr_ba;   addr_d = wr_addr;   end
      StRead:  begin cmd_d = rd_cmd;   ba_d = rd_ba;   addr_d = rd_addr;   end
      default: begin cmd_d = CMD_NOP;  ba_d = IDLE_BA; addr_d = IDLE_ADDR; end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StInit;
      last_wr_q   <= 1'b0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
      ar_en       <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      sdram_cmd   <= CMD_NOP;
      sdram_ba    <= IDLE_BA;
      sdram_addr  <= IDLE_ADDR;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      cnt_q       <= cnt_d;
      timeout_err <= err_d;
      ar_en       <= grant_ar;
      wr_en       <= grant_wr;
      rd_en       <= grant_rd;
      sdram_cmd   <= cmd_d;
      sdram_ba    <= ba_d;
      sdram_addr  <= addr_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed scenarios plus a randomized phase, all
// cycles compared against a bus-ownership reference model.
module tb_sdram_arbiter;

  localparam int Timeout = 1023;
  localparam int OwnInit = 0, OwnIdle = 1, OwnAr = 2, OwnWr = 3, OwnRd = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst, init_done;
  logic [3:0]  init_cmd, ar_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, ar_ba, wr_ba, rd_ba;
  logic [11:0] init_addr, ar_addr, wr_addr, rd_addr;
  logic        ar_req, ar_end, wr_req, wr_end, rd_req, rd_end;
  logic        ar_en, wr_en, rd_en, timeout_err;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;

  sdram_arbiter dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .init_done  (init_done),
    .init_cmd   (init_cmd),
    .init_ba    (init_ba),
    .init_addr  (init_addr),
    .ar_req     (ar_req),
    .ar_end     (ar_end),
    .ar_cmd     (ar_cmd),
    .ar_ba      (ar_ba),
    .ar_addr    (ar_addr),
    .ar_en      (ar_en),
    .wr_req     (wr_req),
    .wr_end     (wr_end),
    .wr_cmd     (wr_cmd),
    .wr_ba      (wr_ba),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .rd_req     (rd_req),
    .rd_end     (rd_end),
    .rd_cmd     (rd_cmd),
    .rd_ba      (rd_ba),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: who owns the bus, how long it has held it, and what the
  // registered outputs must show after the next edge.
  int          m_own = OwnInit;
  int          m_held = 0;
  bit          m_last_wr = 1'b0;
  logic [3:0]  e_cmd;
  logic [1:0]  e_ba;
  logic [11:0] e_addr;
  logic        e_ar_en, e_wr_en, e_rd_en, e_err;

  task automatic model_edge();
    int nxt;
    bit hit, fin;
    if (sys_rst) begin
      m_own = OwnInit; m_held = 0; m_last_wr = 1'b0;
      e_cmd = 4'b0111; e_ba = 2'b11; e_addr = 12'hFFF;
      e_ar_en = 1'b0; e_wr_en = 1'b0; e_rd_en = 1'b0; e_err = 1'b0;
      return;
    end
    case (m_own)
      OwnInit: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      OwnAr:   begin e_cmd = ar_cmd;   e_ba = ar_ba;   e_addr = ar_addr;   end
      OwnWr:   begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
      OwnRd:   begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
      default: begin e_cmd = 4'b0111;  e_ba = 2'b11;   e_addr = 12'hFFF;   end
    endcase
    nxt = m_own;
    hit = 1'b0;
    fin = (m_own == OwnAr && ar_end) || (m_own == OwnWr && wr_end) ||
          (m_own == OwnRd && rd_end);
    if (!init_done) begin
      nxt = OwnInit;
    end else if (m_own == OwnInit) begin
      nxt = OwnIdle;
    end else if (m_own == OwnIdle) begin
      if (ar_req) nxt = OwnAr;
      else if (wr_req && rd_req) nxt = m_last_wr ? OwnRd : OwnWr;
      else if (wr_req) nxt = OwnWr;
      else if (rd_req) nxt = OwnRd;
    end else if (fin) begin
      nxt = OwnIdle;
    end else if (m_held + 1 == Timeout) begin
      nxt = OwnIdle;
      hit = 1'b1;
    end
    e_ar_en = (m_own == OwnIdle) && (nxt == OwnAr);
    e_wr_en = (m_own == OwnIdle) && (nxt == OwnWr);
    e_rd_en = (m_own == OwnIdle) && (nxt == OwnRd);
    if (e_wr_en) m_last_wr = 1'b1;
    if (e_rd_en) m_last_wr = 1'b0;
    if (hit) e_err = 1'b1;
    m_held = (nxt == m_own && nxt >= OwnAr) ? m_held + 1 : 0;
    m_own  = nxt;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // inputs may then be changed by the caller well before the next edge.
  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    cyc++;
    check("cmd",   32'(sdram_cmd),   32'(e_cmd));
    check("ba",    32'(sdram_ba),    32'(e_ba));
    check("addr",  32'(sdram_addr),  32'(e_addr));
    check("ar_en", 32'(ar_en),       32'(e_ar_en));
    check("wr_en", 32'(wr_en),       32'(e_wr_en));
    check("rd_en", 32'(rd_en),       32'(e_rd_en));
    check("err",   32'(timeout_err), 32'(e_err));
  endtask

  task automatic rand_cmds();
    init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 12'($urandom);
    ar_cmd   = 4'($urandom); ar_ba   = 2'($urandom); ar_addr   = 12'($urandom);
    wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 12'($urandom);
    rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 12'($urandom);
  endtask

  task automatic quiet();
    ar_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    ar_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
  endtask

  // Reset, then init_done high; afterwards the bus is idle in arbitration.
  task automatic reset_init();
    quiet();
    sys_rst = 1'b1; init_done = 1'b0;
    cycle();
    sys_rst = 1'b0; init_done = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int since, ngr, owner, nbusy;

    // Reset with init_done low
    rand_cmds();
    quiet();
    sys_rst = 1'b1; init_done = 1'b0;
    cycle();
    cycle();
    check("rst_cmd",  32'(sdram_cmd),  32'(4'b0111));
    check("rst_ba",   32'(sdram_ba),   32'(2'b11));
    check("rst_addr", 32'(sdram_addr), 32'(12'hFFF));
    check("rst_en",   32'({ar_en, wr_en, rd_en}), 32'(0));
    sys_rst = 1'b0;

    // Init phase: requests ignored, bus follows init_cmd one cycle late
    for (int i = 0; i < 20; i++) begin
      rand_cmds();
      ar_req = 1'($urandom); wr_req = 1'($urandom); rd_req = 1'($urandom);
      v = init_cmd;
      cycle();
      check("init_lag", 32'(sdram_cmd), 32'(v));
      check("init_no_en", 32'({ar_en, wr_en, rd_en}), 32'(0));
    end
    quiet();
    init_done = 1'b1;
    cycle();
    cycle();
    check("arbit_nop", 32'(sdram_cmd), 32'(4'b0111));

    // Refresh and write requested together: refresh wins, write follows
    ar_req = 1'b1; wr_req = 1'b1;
    cycle();
    check("ar_first_ar", 32'(ar_en), 32'(1));
    check("ar_first_wr", 32'(wr_en), 32'(0));
    ar_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    ar_end = 1'b1;
    cycle();
    check("wr_after_end0", 32'(wr_en), 32'(0));
    ar_end = 1'b0;
    cycle();
    check("wr_after_end1", 32'(wr_en), 32'(1));
    wr_req = 1'b0;
    cycle();
    check("wr_pulse_only", 32'(wr_en), 32'(0));
    wr_end = 1'b1;
    cycle();
    wr_end = 1'b0;
    cycle();

    // Write and read held high: W,R,W,R from a fresh reset
    reset_init();
    wr_req = 1'b1; rd_req = 1'b1;
    since = 0; ngr = 0; owner = 0;
    for (int i = 0; i < 150 && ngr < 4; i++) begin
      rand_cmds();
      wr_end = (owner == 1 && since == 8);
      rd_end = (owner == 2 && since == 8);
      cycle();
      since++;
      if (wr_en || rd_en) begin
        check("rr_order", wr_en ? 32'd1 : 32'd2, (ngr % 2 == 0) ? 32'd1 : 32'd2);
        ngr++;
        owner = wr_en ? 1 : 2;
        since = 0;
      end
    end
    check("rr_grants", 32'(ngr), 32'd4);
    quiet();
    ar_end = 1'b1; wr_end = 1'b1; rd_end = 1'b1;
    cycle();
    cycle();
    quiet();
    cycle();

    // Refresh request during a write burst waits for wr_end
    wr_req = 1'b1;
    cycle();
    check("burst_grant", 32'(wr_en), 32'(1));
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    ar_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_cmds();
      v = wr_cmd;
      cycle();
      check("burst_cmd", 32'(sdram_cmd), 32'(v));
      check("burst_no_ar", 32'(ar_en), 32'(0));
    end
    wr_end = 1'b1;
    cycle();
    check("burst_end_no_ar", 32'(ar_en), 32'(0));
    wr_end = 1'b0;
    cycle();
    check("burst_then_ar", 32'(ar_en), 32'(1));
    ar_req = 1'b0;
    ar_end = 1'b1;
    cycle();
    ar_end = 1'b0;
    cycle();

    // Read owner that never ends is released after the timeout
    check("to_err_pre", 32'(timeout_err), 32'(0));
    rd_cmd = 4'b0101;
    rd_req = 1'b1;
    cycle();
    check("to_grant", 32'(rd_en), 32'(1));
    rd_req = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 1100; i++) begin
      cycle();
      if (sdram_cmd != 4'b0101) break;
      nbusy++;
    end
    check("to_busy_cycles", 32'(nbusy), 32'(Timeout));
    check("to_err", 32'(timeout_err), 32'(1));
    rd_req = 1'b1;
    cycle();
    check("to_regrant", 32'(rd_en), 32'(1));
    rd_req = 1'b0;
    rd_end = 1'b1;
    cycle();
    rd_end = 1'b0;

    // Reset in the middle of a refresh
    ar_req = 1'b1;
    cycle();
    check("mid_ar_grant", 32'(ar_en), 32'(1));
    ar_req = 1'b0;
    cycle();
    cycle();
    sys_rst = 1'b1;
    cycle();
    check("mid_rst_cmd",  32'(sdram_cmd),  32'(4'b0111));
    check("mid_rst_ba",   32'(sdram_ba),   32'(2'b11));
    check("mid_rst_addr", 32'(sdram_addr), 32'(12'hFFF));
    check("mid_rst_en",   32'({ar_en, wr_en, rd_en}), 32'(0));
    check("mid_rst_err",  32'(timeout_err), 32'(0));
    sys_rst = 1'b0;
    init_cmd = 4'b0011;
    cycle();
    check("mid_rst_init", 32'(sdram_cmd), 32'(4'b0011));

    // Randomized traffic including init_done drops and stray resets
    for (int i = 0; i < 3000; i++) begin
      rand_cmds();
      ar_req    = ($urandom_range(7) == 0);
      wr_req    = 1'($urandom_range(1));
      rd_req    = 1'($urandom_range(1));
      ar_end    = ($urandom_range(5) == 0);
      wr_end    = ($urandom_range(5) == 0);
      rd_end    = ($urandom_range(5) == 0);
      init_done = ($urandom_range(99) != 0);
      sys_rst   = ($urandom_range(499) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
